// File: rtl/record_mode_pkg.sv
// Shared widths, marker encoding and FSM states for the song recorder.
// Optional feature macro: REC_QUANTIZE_EN (rounds written durations to beats).
package record_mode_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 26;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;
  localparam logic [NOTE_W-1:0] END_NOTE  = '0;
  localparam logic [DUR_W-1:0]  END_DUR   = '0;
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_WRITE,
    ST_TERM
  } state_t;

  function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
    return (v == DUR_MAX) ? v : v + DUR_W'(1);
  endfunction

endpackage

// File: rtl/record_mode_timer.sv
// Segment timer: saturating cycle counter with restart, plus optional beat quantiser.
// Optional feature macro: REC_QUANTIZE_EN selects the quantised duration output.
module segment_timer
  import record_mode_pkg::*;
`ifdef REC_QUANTIZE_EN
#(
  parameter int unsigned QUANT = 12_500_000
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             restart,
  input  logic             run,
  output logic [DUR_W-1:0] count,
  output logic [DUR_W-1:0] dur
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (restart) begin
      count <= DUR_W'(1);
    end else if (run) begin
      count <= sat_inc(count);
    end
  end

`ifdef REC_QUANTIZE_EN
  localparam logic [DUR_W-1:0] RES_LAST = DUR_W'(QUANT - 1);
  localparam logic [DUR_W-1:0] RES_HALF = DUR_W'((QUANT + 1) / 2);
  localparam logic [DUR_W-1:0] Q_STEP   = DUR_W'(QUANT);
  localparam int unsigned      PROD_W   = 2 * DUR_W + 1;

  logic [DUR_W-1:0]  beats;
  logic [DUR_W-1:0]  resid;
  logic [DUR_W:0]    rounded;
  logic [PROD_W-1:0] prod;

  // beats*QUANT + resid tracks count without a divider at write time
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      beats <= '0;
      resid <= '0;
    end else if (restart) begin
      if (QUANT == 1) begin
        beats <= DUR_W'(1);
        resid <= '0;
      end else begin
        beats <= '0;
        resid <= DUR_W'(1);
      end
    end else if (run) begin
      if (resid == RES_LAST) begin
        resid <= '0;
        beats <= sat_inc(beats);
      end else begin
        resid <= resid + DUR_W'(1);
      end
    end
  end

  always_comb begin
    rounded = {1'b0, beats} + (DUR_W + 1)'(resid >= RES_HALF);
    if (rounded == '0) begin
      rounded = (DUR_W + 1)'(1);
    end
    prod = PROD_W'(rounded) * PROD_W'(Q_STEP);
    dur  = (prod > PROD_W'(DUR_MAX)) ? DUR_MAX : prod[DUR_W-1:0];
  end
`else
  assign dur = count;
`endif

endmodule

// File: rtl/record_mode.sv
// Keyboard take recorder: turns held-key segments into {note, duration} song memory writes.
// Optional feature macro: REC_QUANTIZE_EN (quantised durations via segment_timer).
module record_mode
  import record_mode_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned MIN_DUR = 1_000_000,
  parameter int unsigned QUANT   = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_on,
  input  logic [NOTE_W-1:0] key,
  input  logic              rec_start,
  input  logic              rec_stop,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [NOTE_W-1:0] mem_wr_note,
  output logic [DUR_W-1:0]  mem_wr_dur,
  output logic              recording,
  output logic              full,
  output logic [CNT_W-1:0]  note_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0]  MIN_CNT   = DUR_W'(MIN_DUR);

  state_t            state;
  state_t            next_state;
  logic [NOTE_W-1:0] cur;
  logic [NOTE_W-1:0] cur_q;
  logic              seg_end;
  logic              seg_long;
  logic              take_seg;
  logic              tmr_clear;
  logic              tmr_restart;
  logic              tmr_run;
  logic [DUR_W-1:0]  seg_cnt;
  logic [DUR_W-1:0]  seg_dur;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0]  count_q;
  logic              full_q;
  logic              stop_pend;
  logic [NOTE_W-1:0] wr_note_q;
  logic [DUR_W-1:0]  wr_dur_q;

  assign cur      = key_on ? key : REST_NOTE;
  assign seg_end  = (cur != cur_q);
  assign seg_long = (seg_cnt >= MIN_CNT);
  assign addr_inc = addr_q + ADDR_W'(1);

  // A stop closes the running segment early: only a sounding one is kept, never a trailing rest
  assign take_seg = seg_long && (rec_stop ? (cur_q != REST_NOTE) : seg_end);

`ifdef REC_QUANTIZE_EN
  segment_timer #(.QUANT(QUANT)) u_timer (
`else
  segment_timer u_timer (
`endif
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .restart (tmr_restart),
    .run     (tmr_run),
    .count   (seg_cnt),
    .dur     (seg_dur)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rec_start) begin
          next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rec_stop) begin
          next_state = ST_TERM;
        end else if (key_on) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (take_seg) begin
          next_state = ST_WRITE;
        end else if (rec_stop) begin
          next_state = ST_TERM;
        end
      end
      ST_WRITE: begin
        if (addr_inc == LAST_ADDR || stop_pend || rec_stop) begin
          next_state = ST_TERM;
        end else begin
          next_state = ST_CAPTURE;
        end
      end
      ST_TERM: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // The timer keeps running through WRITE so the segment that just began loses no cycles
  always_comb begin
    tmr_clear   = 1'b0;
    tmr_restart = 1'b0;
    tmr_run     = 1'b0;
    case (state)
      ST_ARMED: tmr_restart = key_on;
      ST_CAPTURE, ST_WRITE: begin
        tmr_run     = 1'b1;
        tmr_restart = seg_end;
      end
      default: tmr_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q     <= REST_NOTE;
      addr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      stop_pend <= 1'b0;
      wr_note_q <= '0;
      wr_dur_q  <= '0;
    end else begin
      cur_q <= cur;
      case (state)
        ST_IDLE: begin
          if (rec_start) begin
            addr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (take_seg) begin
            wr_note_q <= cur_q;
            wr_dur_q  <= seg_dur;
            stop_pend <= rec_stop;
          end
        end
        ST_WRITE: begin
          addr_q  <= addr_inc;
          count_q <= count_q + CNT_W'(1);
          if (addr_inc == LAST_ADDR) begin
            full_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_note = END_NOTE;
    mem_wr_dur  = END_DUR;
    case (state)
      ST_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = addr_q;
        mem_wr_note = wr_note_q;
        mem_wr_dur  = wr_dur_q;
      end
      ST_TERM: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = addr_q;
      end
      default: ;
    endcase
    recording = (state != ST_IDLE);
  end

  assign full       = full_q;
  assign note_count = count_q;

endmodule

// File: tb/tb_record_mode.sv
// Directed bench for record_mode: stimulus step tables plus expected-write tables.
// Honours REC_QUANTIZE_EN for the expected durations.
module tb_record_mode;

  typedef struct {
    logic        kon;
    logic [3:0]  key;
    logic        start;
    logic        stop;
    int unsigned n;
  } step_t;

  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  note;
    logic [25:0] dur;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_on = 1'b0;
  logic [3:0]  key = '0;
  logic        rec_start = 1'b0;
  logic        rec_stop = 1'b0;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [3:0]  mem_wr_note;
  logic [25:0] mem_wr_dur;
  logic        recording;
  logic        full;
  logic [5:0]  note_count;

  int    vectors = 0;
  int    errors  = 0;
  step_t steps[$];
  wr_t   exp_q[$];
  wr_t   got[$];

  always #5 clk = ~clk;

  record_mode #(.DEPTH(32), .MIN_DUR(4), .QUANT(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_on      (key_on),
    .key         (key),
    .rec_start   (rec_start),
    .rec_stop    (rec_stop),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_note (mem_wr_note),
    .mem_wr_dur  (mem_wr_dur),
    .recording   (recording),
    .full        (full),
    .note_count  (note_count)
  );

  always @(negedge clk) begin
    if (rst && mem_wr_en) got.push_back('{mem_wr_addr, mem_wr_note, mem_wr_dur});
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] qd(input int unsigned d);
`ifdef REC_QUANTIZE_EN
    int unsigned r;
    r = (d + 5) / 10;
    if (r == 0) r = 1;
    return 26'(r * 10);
`else
    return 26'(d);
`endif
  endfunction

  function automatic void add_step(input logic kon, input logic [3:0] k, input logic s,
                                   input logic p, input int unsigned n);
    steps.push_back('{kon, k, s, p, n});
  endfunction

  function automatic void add_exp(input int unsigned a, input int unsigned nt, input logic [25:0] d);
    exp_q.push_back('{5'(a), 4'(nt), d});
  endfunction

  function automatic logic [63:0] pk(input wr_t w);
    return 64'({w.addr, w.note, w.dur});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic run_steps();
    foreach (steps[i]) begin
      key_on    = steps[i].kon;
      key       = steps[i].key;
      rec_start = steps[i].start;
      rec_stop  = steps[i].stop;
      repeat (steps[i].n) tick();
    end
    rec_start = 1'b0;
    rec_stop  = 1'b0;
    steps.delete();
  endtask

  task automatic wait_idle(input string name);
    int unsigned k;
    k = 0;
    while (recording && k < 100) begin
      tick();
      k++;
    end
    tick();
    check({name, " idle"}, 64'(recording), 64'(0));
  endtask

  task automatic check_writes(input string name);
    check({name, " write count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s wr%0d", name, i), pk(got[i]), pk(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check("reset outputs",
          64'({mem_wr_en, mem_wr_addr, mem_wr_note, mem_wr_dur, recording, full, note_count}), 64'(0));
    rst = 1'b1;
    tick();

    // 1: note, rest, note, then stop after a one-cycle trailing rest
    add_step(0, 0, 1, 0, 1);
    add_step(1, 5, 0, 0, 20);
    add_step(0, 0, 0, 0, 8);
    add_step(1, 3, 0, 0, 12);
    add_step(0, 0, 0, 0, 1);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 5, qd(20));
    add_exp(1, 0, qd(8));
    add_exp(2, 3, qd(12));
    add_exp(3, 0, 0);
    run_steps();
    wait_idle("t1");
    check_writes("t1");
    check("t1 note_count", 64'(note_count), 64'(3));
    check("t1 full", 64'(full), 64'(0));

    // 2: leading rest, short press and short gap dropped; rec_start mid-take ignored
    add_step(0, 0, 1, 0, 1);
    add_step(0, 0, 0, 0, 6);
    add_step(1, 1, 0, 0, 2);
    add_step(0, 0, 0, 0, 1);
    add_step(1, 1, 0, 0, 10);
    add_step(1, 1, 1, 0, 1);
    add_step(1, 1, 0, 0, 19);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 1, qd(30));
    add_exp(1, 0, 0);
    run_steps();
    wait_idle("t2");
    check_writes("t2");
    check("t2 note_count", 64'(note_count), 64'(1));

    // 3: fill the memory; marker lands on the reserved last entry
    add_step(0, 0, 1, 0, 1);
    for (int s = 0; s < 36; s++) add_step(1, (s % 2 != 0) ? 4'd4 : 4'd2, 0, 0, 5);
    add_step(0, 0, 0, 0, 2);
    for (int i = 0; i < 31; i++) add_exp(i, (i % 2 != 0) ? 4 : 2, qd(5));
    add_exp(31, 0, 0);
    run_steps();
    wait_idle("t3");
    check_writes("t3");
    check("t3 full", 64'(full), 64'(1));
    check("t3 note_count", 64'(note_count), 64'(31));

    // 4: start+stop together in IDLE (start wins); stop on the release edge
    add_step(0, 0, 1, 1, 1);
    run_steps();
    check("t4 armed", 64'({recording, full, note_count}), 64'({1'b1, 1'b0, 6'd0}));
    add_step(1, 7, 0, 0, 9);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 7, qd(9));
    add_exp(1, 0, 0);
    run_steps();
    wait_idle("t4");
    check_writes("t4");

    // 5: reset mid-take abandons it with no marker
    add_step(0, 0, 1, 0, 1);
    add_step(1, 6, 0, 0, 10);
    add_step(1, 8, 0, 0, 5);
    run_steps();
    check("t5 count before reset", 64'(note_count), 64'(1));
    rst = 1'b0;
    tick();
    check("t5 outputs after reset",
          64'({mem_wr_en, mem_wr_addr, mem_wr_note, mem_wr_dur, recording, full, note_count}), 64'(0));
    rst = 1'b1;
    key_on = 1'b0;
    key = '0;
    repeat (3) tick();
    add_exp(0, 6, qd(10));
    check_writes("t5 abandoned");
    add_step(0, 0, 1, 0, 1);
    add_step(1, 9, 0, 0, 6);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 9, qd(6));
    add_exp(1, 0, 0);
    run_steps();
    wait_idle("t5");
    check_writes("t5 restart");

    // 6: durations around the rounding boundaries and the minimum segment
    add_step(0, 0, 1, 0, 1);
    add_step(1, 1, 0, 0, 14);
    add_step(1, 2, 0, 0, 15);
    add_step(1, 3, 0, 0, 4);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 1, qd(14));
    add_exp(1, 2, qd(15));
    add_exp(2, 3, qd(4));
    add_exp(3, 0, 0);
    run_steps();
    wait_idle("t6");
    check_writes("t6");

    // 7: stop while still armed writes only the marker
    add_step(0, 0, 1, 0, 1);
    add_step(0, 0, 0, 0, 3);
    add_step(0, 0, 0, 1, 1);
    add_exp(0, 0, 0);
    run_steps();
    wait_idle("t7");
    check_writes("t7");
    check("t7 note_count", 64'(note_count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
